// File: rtl/timer_ctrl_seq.sv
// =============================================================================
// timer_ctrl_seq
//
// Avalon-MM master that owns a 16-bit-datapath interval timer (registers 0-5).
// On a configuration handshake it stops the timer, loads the 32-bit period in
// two halves, clears any stale timeout and starts the timer. While running it
// acknowledges every timeout interrupt, emitting a one-cycle tick and a
// wrapping tick count. A level stop request halts the timer.
//
// Optional feature (macro TIMER_CTRL_SEQ_SNAP_EN): counter snapshot. Adds
// snap_req / snap_valid / snap_value and four extra sequencer states that
// latch the timer snapshot registers and read them back.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cfg_valid/ready   configuration handshake (cfg_ready is combinational)
//   cfg_period        timer load value (tick period = load+1 clocks)
//   cfg_continuous    1 = periodic, 0 = one-shot
//   stop_req          level request to halt the timer
//   running           controller is in RUN
//   tick, tick_count  one-cycle pulse per acknowledged timeout, count of them
//   tmr_*             registered Avalon-MM master towards the timer's s1 slave
//   tmr_readdata      timer read data (valid one cycle after the address)
//   tmr_irq           timer interrupt, level, sticky until status write
//   snap_*            (TIMER_CTRL_SEQ_SNAP_EN only) snapshot request/result
// =============================================================================
module timer_ctrl_seq #(
    parameter int TICK_W   = 16,
    parameter int MIN_LOAD = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              stop_req,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
`ifdef TIMER_CTRL_SEQ_SNAP_EN
    ,
    input  logic              snap_req,
    output logic              snap_valid,
    output logic [31:0]       snap_value
`endif
);

    localparam logic [31:0] MIN_LOAD_C = 32'(MIN_LOAD);

    // Timer register map and control-word values
    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  ADDR_PERIODH = 3'd3;
    localparam logic [2:0]  ADDR_SNAPL   = 3'd4;
    localparam logic [2:0]  ADDR_SNAPH   = 3'd5;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;

`ifdef TIMER_CTRL_SEQ_SNAP_EN
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_STOP     = 4'd1,
        ST_WR_PL    = 4'd2,
        ST_WR_PH    = 4'd3,
        ST_CLR_ST   = 4'd4,
        ST_START    = 4'd5,
        ST_RUN      = 4'd6,
        ST_ACK      = 4'd7,
        ST_HALT     = 4'd8,
        ST_SNAP_W   = 4'd9,
        ST_SNAP_RL  = 4'd10,
        ST_SNAP_RH  = 4'd11,
        ST_SNAP_CAP = 4'd12
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_STOP     = 4'd1,
        ST_WR_PL    = 4'd2,
        ST_WR_PH    = 4'd3,
        ST_CLR_ST   = 4'd4,
        ST_START    = 4'd5,
        ST_RUN      = 4'd6,
        ST_ACK      = 4'd7,
        ST_HALT     = 4'd8
    } state_t;
`endif

    state_t              state_r;
    state_t              next_state_s;
    logic                cfg_ready_s;
    logic                accept_s;
    logic [31:0]         load_r;
    logic                cont_r;
    logic                running_r;
    logic                tick_r;
    logic [TICK_W-1:0]   tick_count_r;
    logic [2:0]          bus_addr_s;
    logic                bus_cs_s;
    logic                bus_wn_s;
    logic [15:0]         bus_wd_s;
    logic [2:0]          tmr_address_r;
    logic                tmr_chipselect_r;
    logic                tmr_write_n_r;
    logic [15:0]         tmr_writedata_r;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
    logic [15:0]         snap_lo_r;
    logic [31:0]         snap_value_r;
    logic                snap_valid_r;
`else
    logic                unused_readdata_s;

    // Read data only matters for snapshots; fold it away otherwise
    assign unused_readdata_s = ^tmr_readdata;
`endif

    // Configuration is accepted in IDLE, or in RUN when nothing of higher priority is pending
    always_comb begin
        cfg_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            cfg_ready_s = 1'b1;
        end else if ((state_r == ST_RUN) && !tmr_irq && !stop_req) begin
            cfg_ready_s = 1'b1;
        end else begin
            cfg_ready_s = 1'b0;
        end
    end

    assign accept_s = cfg_valid & cfg_ready_s;

    // Next-state logic of the bus sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STOP:   next_state_s = ST_WR_PL;
            ST_WR_PL:  next_state_s = ST_WR_PH;
            ST_WR_PH:  next_state_s = ST_CLR_ST;
            ST_CLR_ST: next_state_s = ST_START;
            ST_START:  next_state_s = ST_RUN;
            ST_RUN: begin
                if (tmr_irq) begin
                    next_state_s = ST_ACK;
                end else if (stop_req) begin
                    next_state_s = ST_HALT;
                end else if (accept_s) begin
                    next_state_s = ST_STOP;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
                end else if (snap_req) begin
                    next_state_s = ST_SNAP_W;
`endif
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            // A one-shot timer has stopped itself after its timeout
            ST_ACK: begin
                if (cont_r) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HALT:     next_state_s = ST_IDLE;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
            ST_SNAP_W:   next_state_s = ST_SNAP_RL;
            ST_SNAP_RL:  next_state_s = ST_SNAP_RH;
            ST_SNAP_RH:  next_state_s = ST_SNAP_CAP;
            ST_SNAP_CAP: next_state_s = ST_RUN;
`endif
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Bus cycle for the state about to be entered, so the registered bus lines up with it
    always_comb begin
        bus_cs_s   = 1'b0;
        bus_wn_s   = 1'b1;
        bus_addr_s = ADDR_STATUS;
        bus_wd_s   = 16'h0000;
        case (next_state_s)
            ST_STOP: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_CONTROL;
                bus_wd_s   = CTRL_STOP;
            end
            ST_WR_PL: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_PERIODL;
                bus_wd_s   = load_r[15:0];
            end
            ST_WR_PH: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_PERIODH;
                bus_wd_s   = load_r[31:16];
            end
            ST_CLR_ST, ST_ACK: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_STATUS;
                bus_wd_s   = 16'h0000;
            end
            // START | CONT (from the latched mode) | ITO
            ST_START: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_CONTROL;
                bus_wd_s   = {12'h000, 1'b0, 1'b1, cont_r, 1'b1};
            end
            ST_HALT: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_CONTROL;
                bus_wd_s   = CTRL_STOP;
            end
`ifdef TIMER_CTRL_SEQ_SNAP_EN
            // Any write to snapl latches the live counter into the snapshot registers
            ST_SNAP_W: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b0;
                bus_addr_s = ADDR_SNAPL;
                bus_wd_s   = 16'h0000;
            end
            ST_SNAP_RL: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b1;
                bus_addr_s = ADDR_SNAPL;
                bus_wd_s   = 16'h0000;
            end
            ST_SNAP_RH: begin
                bus_cs_s   = 1'b1;
                bus_wn_s   = 1'b1;
                bus_addr_s = ADDR_SNAPH;
                bus_wd_s   = 16'h0000;
            end
`endif
            default: begin
                bus_cs_s   = 1'b0;
                bus_wn_s   = 1'b1;
                bus_addr_s = ADDR_STATUS;
                bus_wd_s   = 16'h0000;
            end
        endcase
    end

    // State, bus, configuration and tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            tmr_address_r    <= 3'd0;
            tmr_chipselect_r <= 1'b0;
            tmr_write_n_r    <= 1'b1;
            tmr_writedata_r  <= 16'h0000;
            load_r           <= 32'h0000_0000;
            cont_r           <= 1'b0;
            running_r        <= 1'b0;
            tick_r           <= 1'b0;
            tick_count_r     <= '0;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
            snap_lo_r        <= 16'h0000;
            snap_value_r     <= 32'h0000_0000;
            snap_valid_r     <= 1'b0;
`endif
        end else begin
            state_r          <= next_state_s;
            tmr_address_r    <= bus_addr_s;
            tmr_chipselect_r <= bus_cs_s;
            tmr_write_n_r    <= bus_wn_s;
            tmr_writedata_r  <= bus_wd_s;
            running_r        <= (next_state_s == ST_RUN);
            tick_r           <= (state_r == ST_ACK);
            if (state_r == ST_ACK) begin
                tick_count_r <= tick_count_r + TICK_W'(1);
            end
            if (accept_s) begin
                load_r <= (cfg_period < MIN_LOAD_C) ? MIN_LOAD_C : cfg_period;
                cont_r <= cfg_continuous;
            end
`ifdef TIMER_CTRL_SEQ_SNAP_EN
            // Read data lags the address by one cycle: snapl arrives in SNAP_RH, snaph in SNAP_CAP
            if (state_r == ST_SNAP_RH) begin
                snap_lo_r <= tmr_readdata;
            end
            if (state_r == ST_SNAP_CAP) begin
                snap_value_r <= {tmr_readdata, snap_lo_r};
            end
            snap_valid_r <= (state_r == ST_SNAP_CAP);
`endif
        end
    end

    assign cfg_ready      = cfg_ready_s;
    assign running        = running_r;
    assign tick           = tick_r;
    assign tick_count     = tick_count_r;
    assign tmr_address    = tmr_address_r;
    assign tmr_chipselect = tmr_chipselect_r;
    assign tmr_write_n    = tmr_write_n_r;
    assign tmr_writedata  = tmr_writedata_r;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
    assign snap_valid     = snap_valid_r;
    assign snap_value     = snap_value_r;
`endif

endmodule

// File: tb/tb_timer_ctrl_seq.sv
// =============================================================================
// tb_timer_ctrl_seq
//
// Bench for timer_ctrl_seq. A behavioural interval timer answers the bus.
// Expected bus transactions are built as a list from the sequencing rules
// (configure, one status clear per timeout, stop) and compared against the
// observed writes; tick spacing, irq-to-tick latency and the tick count are
// checked with plain arithmetic. Configurations are partly randomized.
// Define TIMER_CTRL_SEQ_SNAP_EN to also exercise the snapshot feature.
// =============================================================================
module tb_timer_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_continuous = 1'b0;
    logic        stop_req = 1'b0;
    logic        running;
    logic        tick;
    logic [15:0] tick_count;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;
`ifdef TIMER_CTRL_SEQ_SNAP_EN
    logic        snap_req = 1'b0;
    logic        snap_valid;
    logic [31:0] snap_value;
`endif

    timer_ctrl_seq #(.TICK_W(16), .MIN_LOAD(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .running        (running),
        .tick           (tick),
        .tick_count     (tick_count),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
`ifdef TIMER_CTRL_SEQ_SNAP_EN
        ,
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;

    // Cycle index, advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural interval timer ----------------
    logic [31:0] t_period = 32'd0;
    logic [31:0] t_cnt = 32'd0;
    logic [31:0] t_snap = 32'd0;
    logic        t_run = 1'b0;
    logic        t_to = 1'b0;
    logic        t_ito = 1'b0;
    logic        t_cont = 1'b0;
    logic [15:0] t_rd = 16'd0;

    assign tmr_readdata = t_rd;
    assign tmr_irq      = t_to & t_ito;

    // Timer: count down to zero, flag timeout, reload; bus writes override counting
    always @(posedge clk) begin
        if (t_run) begin
            if (t_cnt == 32'd0) begin
                t_to  <= 1'b1;
                t_cnt <= t_period;
                if (!t_cont) t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 32'd1;
            end
        end
        if (tmr_chipselect && tmr_write_n) begin
            case (tmr_address)
                3'd0:    t_rd <= {14'd0, t_run, t_to};
                3'd1:    t_rd <= {14'd0, t_cont, t_ito};
                3'd2:    t_rd <= t_period[15:0];
                3'd3:    t_rd <= t_period[31:16];
                3'd4:    t_rd <= t_snap[15:0];
                3'd5:    t_rd <= t_snap[31:16];
                default: t_rd <= 16'd0;
            endcase
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito  <= tmr_writedata[0];
                    t_cont <= tmr_writedata[1];
                    if (tmr_writedata[3]) t_run <= 1'b0;
                    else if (tmr_writedata[2]) t_run <= 1'b1;
                end
                3'd2: begin
                    t_period[15:0] <= tmr_writedata;
                    t_cnt <= {t_period[31:16], tmr_writedata};
                    t_run <= 1'b0;
                end
                3'd3: begin
                    t_period[31:16] <= tmr_writedata;
                    t_cnt <= {tmr_writedata, t_period[15:0]};
                    t_run <= 1'b0;
                end
                3'd4, 3'd5: t_snap <= t_cnt;
                default: ;
            endcase
        end
    end

    // ---------------- bookkeeping ----------------
    typedef struct {
        int          cyc;
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t  wq[$];
    int   tq[$];
    int   iq[$];
    int   exp_tc = 0;
    logic irq_q = 1'b0;
    int   check_cnt = 0;
    int   err_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to the next sampling point and log bus writes, ticks and irq rises
    task automatic step();
        wr_t w;
        @(negedge clk);
        if (tmr_chipselect && !tmr_write_n) begin
            w.cyc = cyc;
            w.a   = tmr_address;
            w.d   = tmr_writedata;
            wq.push_back(w);
        end
        if (tick) begin
            tq.push_back(cyc);
            exp_tc = exp_tc + 1;
            check_value("tick_count", 32'(tick_count), 32'(exp_tc % 65536));
        end
        if (tmr_irq && !irq_q) iq.push_back(cyc);
        irq_q = tmr_irq;
    endtask

    task automatic handshake(input logic [31:0] p, input logic c, output int h);
        int n;
        cfg_period     = p;
        cfg_continuous = c;
        cfg_valid      = 1'b1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            step();
            n++;
        end
        check_value("hs_ready", 32'(cfg_ready), 32'd1);
        h = cyc;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_stop();
        int n;
        bit found;
        stop_req = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            step();
            n++;
            if (wq.size() > 0 && wq[$].cyc == cyc && wq[$].a == 3'd1 && wq[$].d == 16'h0008)
                found = 1'b1;
        end
        check_value("halt_write", 32'(found), 32'd1);
        step();
        check_value("halt_running", 32'(running), 32'd0);
        check_value("halt_ready", 32'(cfg_ready), 32'd1);
        check_value("halt_cs", 32'(tmr_chipselect), 32'd0);
        // stop_req in IDLE is ignored: bus stays quiet
        repeat (3) step();
        check_value("idle_stop_cs", 32'(tmr_chipselect), 32'd0);
        stop_req = 1'b0;
    endtask

    // Compare every write after cycle h with the list the sequencing rules predict
    task automatic check_list(input int h, input logic [31:0] L, input logic c,
                              input int nack, input bit halted);
        logic [2:0]  ea[$];
        logic [15:0] ed[$];
        int k;
        ea.push_back(3'd1); ed.push_back(16'h0008);
        ea.push_back(3'd2); ed.push_back(L[15:0]);
        ea.push_back(3'd3); ed.push_back(L[31:16]);
        ea.push_back(3'd0); ed.push_back(16'h0000);
        ea.push_back(3'd1); ed.push_back({12'd0, 1'b0, 1'b1, c, 1'b1});
        for (int i = 0; i < nack; i++) begin
            ea.push_back(3'd0); ed.push_back(16'h0000);
        end
        if (halted) begin
            ea.push_back(3'd1); ed.push_back(16'h0008);
        end
        k = 0;
        foreach (wq[i]) begin
            if (wq[i].cyc > h) begin
                if (k < ea.size()) begin
                    check_value($sformatf("wr%0d_addr", k), 32'(wq[i].a), 32'(ea[k]));
                    check_value($sformatf("wr%0d_data", k), 32'(wq[i].d), 32'(ed[k]));
                end
                k++;
            end
        end
        check_value("wr_count", 32'(k), 32'(ea.size()));
    endtask

    task automatic run_config(input logic [31:0] p, input logic c, input int nt,
                              input bit stop_after, output int h);
        logic [31:0] L;
        int base_t, target, n, k;
        bit hit;
        handshake(p, c, h);
        repeat (5) step();
        check_value("running", 32'(running), 32'd1);
        // configuration writes occupy the five cycles right after the handshake
        k = 0;
        foreach (wq[i]) begin
            if (wq[i].cyc > h && k < 5) begin
                check_value($sformatf("cfg_cycle%0d", k), 32'(wq[i].cyc), 32'(h + 1 + k));
                k++;
            end
        end
        L = (p < 32'd15) ? 32'd15 : p;
        base_t = tq.size();
        target = c ? nt : 1;
        n = 0;
        while ((tq.size() - base_t) < target && n < (target + 1) * (int'(L) + 1) + 100) begin
            step();
            n++;
        end
        check_value("ticks_seen", 32'(tq.size() - base_t), 32'(target));
        for (int i = base_t; i < tq.size(); i++) begin
            if (i > base_t)
                check_value("tick_interval", 32'(tq[i] - tq[i-1]), L + 32'd1);
            hit = 1'b0;
            foreach (iq[j]) if (iq[j] == tq[i] - 2) hit = 1'b1;
            check_value("irq_to_tick", 32'(hit), 32'd1);
        end
        if (!c) begin
            repeat (3 * (int'(L) + 1)) step();
            check_value("oneshot_ticks", 32'(tq.size() - base_t), 32'd1);
            check_value("oneshot_running", 32'(running), 32'd0);
            check_value("oneshot_ready", 32'(cfg_ready), 32'd1);
            check_value("oneshot_irq", 32'(tmr_irq), 32'd0);
            check_list(h, L, c, tq.size() - base_t, 1'b0);
        end else if (stop_after) begin
            do_stop();
            check_list(h, L, c, tq.size() - base_t, 1'b1);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int h;
        logic [31:0] p;
        logic c;
        bit st;
        bit in_run;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        step();
        check_value("rst_ready", 32'(cfg_ready), 32'd1);
        check_value("rst_cs", 32'(tmr_chipselect), 32'd0);
        check_value("rst_wn", 32'(tmr_write_n), 32'd1);
        check_value("rst_tick_count", 32'(tick_count), 32'd0);
        check_value("rst_running", 32'(running), 32'd0);

        run_config(32'h0001_0010, 1'b1, 0, 1'b1, h);
        run_config(32'd99, 1'b1, 3, 1'b1, h);
        run_config(32'd49, 1'b0, 1, 1'b0, h);
        run_config(32'd3, 1'b1, 2, 1'b1, h);

        in_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 30)) : 32'($urandom_range(31, 150));
            c  = 1'($urandom_range(0, 1));
            st = c ? 1'($urandom_range(0, 1)) : 1'b0;
            run_config(p, c, $urandom_range(1, 3), st, h);
            in_run = c & ~st;
        end
        if (in_run) do_stop();

        // reset in the middle of a configuration sequence
        handshake(32'd100, 1'b1, h);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_tc = 0;
        check_value("midrst_cs", 32'(tmr_chipselect), 32'd0);
        check_value("midrst_running", 32'(running), 32'd0);
        check_value("midrst_ready", 32'(cfg_ready), 32'd1);
        check_value("midrst_tick_count", 32'(tick_count), 32'd0);
        repeat (3) step();
        check_value("midrst_idle_cs", 32'(tmr_chipselect), 32'd0);
        run_config(32'd20, 1'b1, 2, 1'b1, h);

`ifdef TIMER_CTRL_SEQ_SNAP_EN
        begin
            int n, s;
            logic [31:0] e, diff;
            run_config(32'h000F_FFFF, 1'b1, 0, 1'b0, h);
            repeat (494) step();
            snap_req = 1'b1;
            step();
            snap_req = 1'b0;
            n = 0;
            while (!snap_valid && n < 20) begin
                step();
                n++;
            end
            check_value("snap_valid", 32'(snap_valid), 32'd1);
            s = 0;
            foreach (wq[i]) if (wq[i].a == 3'd4 && wq[i].cyc > h) s = wq[i].cyc;
            e = 32'h000F_FFFF - 32'(s - (h + 5));
            diff = (snap_value > e) ? (snap_value - e) : (e - snap_value);
            check_value("snap_value_close", 32'(diff <= 32'd1), 32'd1);
            step();
            check_value("snap_valid_pulse", 32'(snap_valid), 32'd0);
            do_stop();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
